// File: rtl/img_pkg.sv
// Shared constants, enums and saturation helper for the 3x3 image convolution stage.
package img_pkg;

  localparam int unsigned PIX_W = 12;
  localparam int unsigned IMG_W = 256;
  localparam int unsigned IMG_H = 256;
  localparam int unsigned SUM_W = PIX_W + 2;
  localparam int unsigned ACC_W = PIX_W + 6;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_GAUSS = 2'd1,
    MODE_SHARP = 2'd2,
    MODE_SOBEL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Stage-1 payload: centre pixel plus the partial sums every kernel needs
  typedef struct packed {
    logic             valid;
    logic             border;
    logic [PIX_W-1:0] c;
    logic [SUM_W-1:0] corners;
    logic [SUM_W-1:0] edges;
    logic [SUM_W-1:0] gx_pos;
    logic [SUM_W-1:0] gx_neg;
    logic [SUM_W-1:0] gy_pos;
    logic [SUM_W-1:0] gy_neg;
  } s1_t;

  typedef struct packed {
    logic             valid;
    logic             border;
    logic [PIX_W-1:0] c;
    logic [ACC_W-1:0] val;
  } s2_t;

  // Clamp a two's-complement accumulator to the unsigned pixel range
  function automatic logic [PIX_W-1:0] sat12(input logic [ACC_W-1:0] v);
    if (v[ACC_W-1]) begin
      return '0;
    end else if (|v[ACC_W-2:PIX_W]) begin
      return '1;
    end
    return v[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/img_kernel_dp.sv
// Three-stage 3x3 kernel datapath: partial sums, kernel combine, saturate/border select.
module img_kernel_dp
  import img_pkg::*;
#(
  parameter int unsigned BORDER_PASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  input  logic                 i_border,
  input  mode_e                i_mode,
  input  logic [3*PIX_W-1:0]   i_row0,
  input  logic [3*PIX_W-1:0]   i_row1,
  input  logic [3*PIX_W-1:0]   i_row2,
  output logic                 o_valid,
  output logic [PIX_W-1:0]     o_pixel,
  output logic                 o_busy_c
);

  logic [PIX_W-1:0] w_tl, w_t, w_tr, w_l, w_c, w_r, w_bl, w_b, w_br;
  s1_t              w_s1, r_s1;
  s2_t              r_s2;
  logic [ACC_W-1:0] w_gsum, w_sharp, w_gx, w_gy, w_ax, w_ay, w_val;
  logic             r_out_valid;
  logic [PIX_W-1:0] r_out_pixel;

  function automatic logic [SUM_W-1:0] tap121(input logic [PIX_W-1:0] a,
                                              input logic [PIX_W-1:0] b,
                                              input logic [PIX_W-1:0] c);
    return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
  endfunction

  assign w_tl = i_row0[PIX_W-1:0];
  assign w_t  = i_row0[2*PIX_W-1:PIX_W];
  assign w_tr = i_row0[3*PIX_W-1:2*PIX_W];
  assign w_l  = i_row1[PIX_W-1:0];
  assign w_c  = i_row1[2*PIX_W-1:PIX_W];
  assign w_r  = i_row1[3*PIX_W-1:2*PIX_W];
  assign w_bl = i_row2[PIX_W-1:0];
  assign w_b  = i_row2[2*PIX_W-1:PIX_W];
  assign w_br = i_row2[3*PIX_W-1:2*PIX_W];

  always_comb begin
    w_s1         = '0;
    w_s1.valid   = i_valid;
    w_s1.border  = i_border;
    w_s1.c       = w_c;
    w_s1.corners = SUM_W'(w_tl) + SUM_W'(w_tr) + SUM_W'(w_bl) + SUM_W'(w_br);
    w_s1.edges   = SUM_W'(w_t) + SUM_W'(w_b) + SUM_W'(w_l) + SUM_W'(w_r);
    w_s1.gx_pos  = tap121(w_tr, w_r, w_br);
    w_s1.gx_neg  = tap121(w_tl, w_l, w_bl);
    w_s1.gy_pos  = tap121(w_bl, w_b, w_br);
    w_s1.gy_neg  = tap121(w_tl, w_t, w_tr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
    end else if (i_valid) begin
      r_s1 <= w_s1;
    end else begin
      r_s1.valid <= 1'b0;
    end
  end

  // Kernel combine; all arithmetic is modulo 2^ACC_W so negatives land as two's complement
  always_comb begin
    w_gsum  = ACC_W'(r_s1.corners) + (ACC_W'(r_s1.edges) << 1) + (ACC_W'(r_s1.c) << 2) + ACC_W'(8);
    w_sharp = ACC_W'(r_s1.c) * ACC_W'(5) - ACC_W'(r_s1.edges);
    w_gx    = ACC_W'(r_s1.gx_pos) - ACC_W'(r_s1.gx_neg);
    w_gy    = ACC_W'(r_s1.gy_pos) - ACC_W'(r_s1.gy_neg);
    w_ax    = w_gx[ACC_W-1] ? -w_gx : w_gx;
    w_ay    = w_gy[ACC_W-1] ? -w_gy : w_gy;
    w_val   = ACC_W'(r_s1.c);
    unique case (i_mode)
      MODE_PASS:  w_val = ACC_W'(r_s1.c);
      MODE_GAUSS: w_val = w_gsum >> 4;
      MODE_SHARP: w_val = w_sharp;
      MODE_SOBEL: w_val = w_ax + w_ay;
      default:    w_val = ACC_W'(r_s1.c);
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2 <= '0;
    end else if (r_s1.valid) begin
      r_s2.valid  <= 1'b1;
      r_s2.border <= r_s1.border;
      r_s2.c      <= r_s1.c;
      r_s2.val    <= w_val;
    end else begin
      r_s2.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_pixel <= '0;
    end else begin
      r_out_valid <= r_s2.valid;
      if (r_s2.valid) begin
        r_out_pixel <= ((BORDER_PASS != 0) && r_s2.border) ? r_s2.c : sat12(r_s2.val);
      end
    end
  end

  assign o_valid  = r_out_valid;
  assign o_pixel  = r_out_pixel;
  assign o_busy_c = r_s1.valid | r_s2.valid;

endmodule

// File: rtl/img_conv3x3.sv
// Frame sequencer for the 3x3 convolution stage: FSM, frame position counters and mode latch.
module img_conv3x3
  import img_pkg::*;
#(
  parameter int unsigned IMG_W       = img_pkg::IMG_W,
  parameter int unsigned IMG_H       = img_pkg::IMG_H,
  parameter int unsigned PIX_W       = img_pkg::PIX_W,
  parameter int unsigned BORDER_PASS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic                 win_valid,
  input  logic [3*PIX_W-1:0]   row0,
  input  logic [3*PIX_W-1:0]   row1,
  input  logic [3*PIX_W-1:0]   row2,
  output logic                 out_valid,
  output logic [PIX_W-1:0]     out_pixel,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned TOTAL = IMG_W * IMG_H;
  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  state_e           r_state, w_state_nxt;
  mode_e            r_mode;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic [CNT_W-1:0] r_count;
  logic             r_busy, r_done;
  logic             w_busy_nxt, w_done_nxt;
  logic             w_accept, w_last, w_border, w_pipe_busy;

  assign w_accept = (r_state == RUN) && win_valid;
  assign w_last   = w_accept && (r_count == CNT_W'(TOTAL - 1));
  assign w_border = (r_row == '0) || (r_row == ROW_W'(IMG_H - 1)) ||
                    (r_col == '0) || (r_col == COL_W'(IMG_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // DRAIN only needs the two internal stages empty: the output stage is then showing the last result
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DRAIN;
      DRAIN:   if (!w_pipe_busy) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    unique case (w_state_nxt)
      RUN, DRAIN: w_busy_nxt = 1'b1;
      DONE:       w_done_nxt = 1'b1;
      default:    w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode  <= MODE_PASS;
      r_col   <= '0;
      r_row   <= '0;
      r_count <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_mode  <= mode_e'(mode);
      r_col   <= '0;
      r_row   <= '0;
      r_count <= '0;
    end else if (w_accept) begin
      r_count <= r_count + CNT_W'(1);
      if (r_col == COL_W'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  img_kernel_dp #(
    .BORDER_PASS (BORDER_PASS)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .i_valid  (w_accept),
    .i_border (w_border),
    .i_mode   (r_mode),
    .i_row0   (row0),
    .i_row1   (row1),
    .i_row2   (row2),
    .o_valid  (out_valid),
    .o_pixel  (out_pixel),
    .o_busy_c (w_pipe_busy)
  );

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_img_conv3x3.sv
// Directed bench for img_conv3x3 on a reduced 8x6 frame with BORDER_PASS enabled.
module tb_img_conv3x3;

  localparam int TW    = 8;
  localparam int TH    = 6;
  localparam int TOTAL = TW * TH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic        win_valid = 1'b0;
  logic [35:0] row0 = '0, row1 = '0, row2 = '0;
  logic        out_valid;
  logic [11:0] out_pixel;
  logic        busy, done;

  img_conv3x3 #(
    .IMG_W       (TW),
    .IMG_H       (TH),
    .PIX_W       (12),
    .BORDER_PASS (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .win_valid (win_valid),
    .row0      (row0),
    .row1      (row1),
    .row2      (row2),
    .out_valid (out_valid),
    .out_pixel (out_pixel),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [11:0] got_q[$];
  int first_ov_cyc = -1, last_ov_cyc = -1, done_cyc = -1, done_cnt = 0;
  int first_drive_cyc = -1;

  always @(negedge clk) begin
    if (out_valid) begin
      if (got_q.size() == 0) first_ov_cyc = cyc;
      got_q.push_back(out_pixel);
      last_ov_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [35:0] mk(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    return {r, c, l};
  endfunction

  typedef struct {
    string       name;
    logic [1:0]  m;
    int          pos;
    logic [35:0] r0, r1, r2;
    logic [11:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input string nm, input logic [1:0] m, input int pos,
                         input logic [35:0] r0, input logic [35:0] r1, input logic [35:0] r2,
                         input logic [11:0] exp);
    vec_t v;
    v.name = nm; v.m = m; v.pos = pos; v.r0 = r0; v.r1 = r1; v.r2 = r2; v.exp = exp;
    vq.push_back(v);
  endtask

  task automatic start_frame(input logic [1:0] m);
    start = 1'b1;
    mode  = m;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  // One frame: all windows zero except tpos (or a running centre count), optional gaps and stray start
  task automatic run_frame(input logic [1:0] m, input int gap_pct, input bit count_ctr, input bit poke,
                           input int tpos, input logic [35:0] t0, input logic [35:0] t1,
                           input logic [35:0] t2, output int dones);
    int k;
    int d0;
    bit seen;
    d0 = done_cnt;
    got_q.delete();
    first_ov_cyc = -1;
    first_drive_cyc = -1;
    start_frame(m);
    k = 0;
    while (k < TOTAL) begin
      start = poke && (k == 5);
      if (poke && k == 5) mode = 2'd2;
      if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
        win_valid = 1'b0;
        row0 = 36'($urandom); row1 = 36'($urandom); row2 = 36'($urandom);
      end else begin
        win_valid = 1'b1;
        if (k == tpos) begin
          row0 = t0; row1 = t1; row2 = t2;
        end else if (count_ctr) begin
          row0 = 36'($urandom);
          row1 = mk(12'($urandom), 12'(k), 12'($urandom));
          row2 = 36'($urandom);
        end else begin
          row0 = '0; row1 = '0; row2 = '0;
        end
        if (k == 0) first_drive_cyc = cyc;
        k++;
      end
      tick();
    end
    start = 1'b0;
    win_valid = 1'b1;
    row1 = mk(12'h0, 12'hEEE, 12'h0);
    repeat (4) tick();
    win_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (done_cnt > d0) seen = 1'b1;
      else tick();
    end
    if (!seen) chk("done_timeout", 0, 1);
    repeat (3) tick();
    dones = done_cnt - d0;
    chk("busy_after_frame", int'(busy), 0);
  endtask

  initial begin
    int dn;
    logic [35:0] ALLF, Z;
    ALLF = '1;
    Z    = '0;

    add_vec("gauss_all_fff",  2'd1,  9, ALLF, ALLF, ALLF, 12'hFFF);
    add_vec("gauss_centre10", 2'd1,  9, Z, mk(12'h0, 12'h010, 12'h0), Z, 12'h004);
    add_vec("gauss_mixed",    2'd1,  9, mk(12'h010, 12'h020, 12'h010), mk(12'h020, 12'h040, 12'h020),
            mk(12'h010, 12'h020, 12'h010), 12'h024);
    add_vec("sharp_sat_hi",   2'd2,  9, Z, mk(12'h0, 12'hFFF, 12'h0), Z, 12'hFFF);
    add_vec("sharp_sat_lo",   2'd2,  9, mk(12'h100, 12'h100, 12'h100), mk(12'h100, 12'h000, 12'h100),
            mk(12'h100, 12'h100, 12'h100), 12'h000);
    add_vec("sharp_mixed",    2'd2,  9, mk(12'hFFF, 12'h010, 12'hFFF), mk(12'h030, 12'h200, 12'h040),
            mk(12'hFFF, 12'h020, 12'hFFF), 12'h960);
    add_vec("sobel_edge_sat", 2'd3,  9, mk(12'h0, 12'h800, 12'hFFF), mk(12'h0, 12'h800, 12'hFFF),
            mk(12'h0, 12'h800, 12'hFFF), 12'hFFF);
    add_vec("sobel_uniform",  2'd3,  9, mk(12'h800, 12'h800, 12'h800), mk(12'h800, 12'h800, 12'h800),
            mk(12'h800, 12'h800, 12'h800), 12'h000);
    add_vec("sobel_diag",     2'd3,  9, mk(12'h100, 12'h0, 12'h0), Z, mk(12'h0, 12'h0, 12'h010), 12'h1E0);
    add_vec("pass_centre",    2'd0,  9, mk(12'h111, 12'h222, 12'h333), mk(12'h444, 12'hABC, 12'h555),
            mk(12'h666, 12'h777, 12'h888), 12'hABC);
    add_vec("border_col0",    2'd2, 16, Z, mk(12'h0, 12'h123, 12'h0), Z, 12'h123);
    add_vec("border_col0_sb", 2'd3,  8, mk(12'h0, 12'h800, 12'hFFF), mk(12'h0, 12'h800, 12'hFFF),
            mk(12'h0, 12'h800, 12'hFFF), 12'h800);
    add_vec("border_row0",    2'd1,  3, ALLF, mk(12'hFFF, 12'h555, 12'hFFF), ALLF, 12'h555);
    add_vec("border_last",    2'd2, 47, ALLF, mk(12'hFFF, 12'h7FF, 12'hFFF), ALLF, 12'h7FF);
    add_vec("interior_neg",   2'd2, 10, ALLF, mk(12'hFFF, 12'h7FF, 12'hFFF), ALLF, 12'h000);

    // Reset state
    repeat (3) tick();
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_pixel", int'(out_pixel), 0);
    chk("rst_busy",      int'(busy), 0);
    chk("rst_done",      int'(done), 0);
    rst = 1'b0;
    repeat (2) tick();

    foreach (vq[i]) begin
      run_frame(vq[i].m, 0, 1'b0, 1'b0, vq[i].pos, vq[i].r0, vq[i].r1, vq[i].r2, dn);
      chk({vq[i].name, "_count"}, got_q.size(), TOTAL);
      if (got_q.size() > vq[i].pos) chk(vq[i].name, int'(got_q[vq[i].pos]), int'(vq[i].exp));
      chk({vq[i].name, "_dones"}, dn, 1);
    end

    // Gapless pass-through frame: latency, ordering, done timing
    run_frame(2'd0, 0, 1'b1, 1'b0, -1, Z, Z, Z, dn);
    chk("pass_count", got_q.size(), TOTAL);
    for (int k = 0; k < TOTAL && k < got_q.size(); k++) chk("pass_seq", int'(got_q[k]), k);
    chk("latency", first_ov_cyc - first_drive_cyc, 3);
    chk("done_after_last", done_cyc - last_ov_cyc, 1);
    chk("pass_dones", dn, 1);

    // Gappy frame with a stray start and mode change while busy
    run_frame(2'd0, 35, 1'b1, 1'b1, -1, Z, Z, Z, dn);
    chk("gap_count", got_q.size(), TOTAL);
    for (int k = 0; k < TOTAL && k < got_q.size(); k++) chk("gap_seq", int'(got_q[k]), k);
    chk("gap_done_after_last", done_cyc - last_ov_cyc, 1);
    chk("gap_dones", dn, 1);

    // Reset in the middle of a frame
    start_frame(2'd0);
    for (int k = 0; k < 20; k++) begin
      win_valid = 1'b1;
      row1 = mk(12'h0, 12'(k + 1), 12'h0);
      tick();
    end
    win_valid = 1'b0;
    chk("mid_pre_out_pixel", int'(out_pixel != 12'h0), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_out_pixel", int'(out_pixel), 0);
    chk("mid_rst_busy",      int'(busy), 0);
    chk("mid_rst_done",      int'(done), 0);
    begin
      int d0;
      d0 = done_cnt;
      tick(); tick();
      rst = 1'b0;
      repeat (10) tick();
      chk("mid_rst_no_done", done_cnt - d0, 0);
      chk("mid_rst_idle_busy", int'(busy), 0);
    end
    run_frame(2'd0, 0, 1'b1, 1'b0, -1, Z, Z, Z, dn);
    chk("post_rst_count", got_q.size(), TOTAL);
    for (int k = 0; k < TOTAL && k < got_q.size(); k++) chk("post_rst_seq", int'(got_q[k]), k);
    chk("post_rst_dones", dn, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
